// File: rtl/fp_accum_if.sv
// Stream/control bundle for fp_accum: start/len command, element stream, result and status.
interface fp_accum_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic [31:0]      acc_out;
  logic             busy;
  logic             done;
  logic             nan_flag;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, acc_out, busy, done, nan_flag
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, acc_out, busy, done, nan_flag
  );
endinterface

// File: rtl/fp_accum.sv
// Sequential single-precision accumulator around a combinational RNE fp_adder.
// Optional sticky NaN/Inf input detection: define FP_ACCUM_NAN_DETECT_EN.
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic        w_swap, w_sx, w_sy, w_sub, w_stk, w_rnd;
  logic [7:0]  w_ex, w_ey, w_d, w_sh;
  logic [23:0] w_mx, w_my;
  logic [26:0] w_yal, w_my27, w_n;
  logic [27:0] w_s;
  logic [4:0]  w_lz;
  logic [9:0]  w_e, w_ef;
  logic [24:0] w_m;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  assign w_a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign w_b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign w_a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign w_b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

  // Order operands by magnitude so the alignment shift is always on y.
  assign w_swap = a[30:0] < b[30:0];
  assign w_sx   = w_swap ? b[31] : a[31];
  assign w_sy   = w_swap ? a[31] : b[31];
  assign w_ex   = w_swap ? ((b[30:23] == 8'd0) ? 8'd1 : b[30:23]) : ((a[30:23] == 8'd0) ? 8'd1 : a[30:23]);
  assign w_ey   = w_swap ? ((a[30:23] == 8'd0) ? 8'd1 : a[30:23]) : ((b[30:23] == 8'd0) ? 8'd1 : b[30:23]);
  assign w_mx   = w_swap ? {|b[30:23], b[22:0]} : {|a[30:23], a[22:0]};
  assign w_my   = w_swap ? {|a[30:23], a[22:0]} : {|b[30:23], b[22:0]};
  assign w_d    = w_ex - w_ey;
  assign w_sub  = w_sx ^ w_sy;
  assign w_my27 = {w_my, 3'b000};

  always_comb begin
    w_yal = 27'd0;
    w_stk = 1'b0;
    w_sh  = 8'd0;
    w_n   = 27'd0;
    w_e   = 10'd0;
    w_lz  = 5'd0;
    if (w_d >= 8'd27) begin
      w_stk = |w_my27;
    end else begin
      w_yal = w_my27 >> w_d;
      w_stk = ((w_yal << w_d) != w_my27);
    end
    w_yal[0] = w_yal[0] | w_stk;
    w_s = w_sub ? ({1'b0, w_mx, 3'b000} - {1'b0, w_yal}) : ({1'b0, w_mx, 3'b000} + {1'b0, w_yal});
    if (w_s[27]) begin
      w_n = {w_s[27:2], w_s[1] | w_s[0]};
      w_e = {2'b00, w_ex} + 10'd1;
    end else begin
      // Left-normalise, but never below exponent 1 (subnormal result).
      w_lz = lzc27(w_s[26:0]);
      w_sh = ({3'b000, w_lz} < w_ex) ? {3'b000, w_lz} : (w_ex - 8'd1);
      w_n  = w_s[26:0] << w_sh;
      w_e  = {2'b00, w_ex} - {2'b00, w_sh};
    end
    w_rnd = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_m   = {1'b0, w_n[26:3]} + {24'd0, w_rnd};
    w_ef  = w_m[24] ? (w_e + 10'd1) : (w_m[23] ? w_e : 10'd0);

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != b[31])))
      sum = 32'h7FC00000;
    else if (w_a_inf)
      sum = a;
    else if (w_b_inf)
      sum = b;
    else if (w_s == 28'd0)
      sum = {w_sx & w_sy, 31'd0};
    else if (w_ef >= 10'd255)
      sum = {w_sx, 8'hFF, 23'd0};
    else
      sum = {w_sx, w_ef[7:0], (w_m[24] ? 23'd0 : w_m[22:0])};
  end
endmodule

module fp_accum #(
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     reset,
  fp_accum_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready, r_busy, r_done;
  logic [31:0]      w_sum;
  logic             w_hs;

  fp_adder u_add (.a(r_acc), .b(bus.in_data), .sum(w_sum));

  assign w_hs = bus.in_valid & r_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= 32'd0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_acc  <= 32'd0;
          r_cnt  <= bus.len;
          r_busy <= 1'b1;
          if (bus.len == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_ACCUM;
            r_in_ready <= 1'b1;
          end
        end
        S_ACCUM: if (w_hs) begin
          r_acc <= w_sum;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state    <= S_DONE;
            r_in_ready <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FP_ACCUM_NAN_DETECT_EN
  logic r_nan;
  // Sticky until the next accepted start; exponent all-ones covers NaN and Inf.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_nan <= 1'b0;
    else if (r_state == S_IDLE && bus.start)
      r_nan <= 1'b0;
    else if (w_hs && bus.in_data[30:23] == 8'hFF)
      r_nan <= 1'b1;
  end
  assign bus.nan_flag = r_nan;
`else
  assign bus.nan_flag = 1'b0;
`endif

  assign bus.in_ready = r_in_ready;
  assign bus.acc_out  = r_acc;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum: handshake timing, gaps, len=0, ignored starts, async reset, NaN flag.
module tb_fp_accum;
  logic clk, reset;
  int   checks = 0, failures = 0;
  int   hs_cnt = 0, done_cnt = 0, hs0, d0;
  logic rdy_seen = 1'b0;

`ifdef FP_ACCUM_NAN_DETECT_EN
  localparam logic NAN_EXP = 1'b1;
`else
  localparam logic NAN_EXP = 1'b0;
`endif

  fp_accum_if #(.CNT_W(8)) bus ();
  fp_accum #(.CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) hs_cnt++;
    if (bus.done) done_cnt++;
    if (bus.in_ready) rdy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic start_seq(input logic [7:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    chk("rdy_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEADBEEF;
  endtask

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    #3;
    chk("rst_acc", bus.acc_out, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_nan", {31'd0, bus.nan_flag}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // 1 + 1
    start_seq(8'd2);
    chk("t1_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    chk("t1_acc0", bus.acc_out, 32'h0);
    send(32'h3F800000);
    chk("t1_acc1", bus.acc_out, 32'h3F800000);
    chk("t1_nodone", {31'd0, bus.done}, 32'd0);
    send(32'h3F800000);
    chk("t1_done", {31'd0, bus.done}, 32'd1);
    chk("t1_sum", bus.acc_out, 32'h40000000);
    chk("t1_rdy_lo", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("t1_done_lo", {31'd0, bus.done}, 32'd0);
    chk("t1_busy_lo", {31'd0, bus.busy}, 32'd0);

    // 1 + 0.5 + 2.25 with gaps
    hs0 = hs_cnt;
    start_seq(8'd3);
    send(32'h3F800000);
    repeat (2) @(negedge clk);
    chk("t2_hold", bus.acc_out, 32'h3F800000);
    send(32'h3F000000);
    chk("t2_acc2", bus.acc_out, 32'h3FC00000);
    repeat (2) @(negedge clk);
    send(32'h40100000);
    chk("t2_done", {31'd0, bus.done}, 32'd1);
    chk("t2_sum", bus.acc_out, 32'h40700000);
    chk("t2_hs", hs_cnt - hs0, 32'd3);
    @(negedge clk);

    // len == 0
    rdy_seen = 1'b0;
    start_seq(8'd0);
    chk("t3_done", {31'd0, bus.done}, 32'd1);
    chk("t3_acc", bus.acc_out, 32'h0);
    chk("t3_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("t3_done_lo", {31'd0, bus.done}, 32'd0);
    chk("t3_no_rdy", {31'd0, rdy_seen}, 32'd0);

    // -1 + 1 with start pulses in ACCUM and DONE
    d0 = done_cnt;
    start_seq(8'd2);
    send(32'hBF800000);
    bus.start = 1'b1; bus.len = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t4_acc_keep", bus.acc_out, 32'hBF800000);
    chk("t4_rdy_keep", {31'd0, bus.in_ready}, 32'd1);
    send(32'h3F800000);
    chk("t4_done", {31'd0, bus.done}, 32'd1);
    chk("t4_sum", bus.acc_out, 32'h00000000);
    bus.start = 1'b1; bus.len = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t4_dstart_busy", {31'd0, bus.busy}, 32'd0);
    chk("t4_dstart_rdy", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("t4_one_done", done_cnt - d0, 32'd1);

    // async reset mid-sequence
    d0 = done_cnt;
    start_seq(8'd4);
    send(32'h3F800000);
    send(32'h3F800000);
    chk("t5_mid", bus.acc_out, 32'h40000000);
    #2 reset = 1'b1;
    #1;
    chk("t5_acc", bus.acc_out, 32'h0);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("t5_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 32'd0);
    start_seq(8'd1);
    send(32'h3F800000);
    chk("t5_done2", {31'd0, bus.done}, 32'd1);
    chk("t5_sum2", bus.acc_out, 32'h3F800000);
    @(negedge clk);

    // NaN input
    start_seq(8'd2);
    chk("t6_nan0", {31'd0, bus.nan_flag}, 32'd0);
    send(32'h7FC00000);
    chk("t6_nan1", {31'd0, bus.nan_flag}, {31'd0, NAN_EXP});
    send(32'h3F800000);
    chk("t6_done", {31'd0, bus.done}, 32'd1);
    chk("t6_nan_done", {31'd0, bus.nan_flag}, {31'd0, NAN_EXP});
    @(negedge clk);
    chk("t6_nan_idle", {31'd0, bus.nan_flag}, {31'd0, NAN_EXP});
    start_seq(8'd0);
    chk("t6_nan_clr", {31'd0, bus.nan_flag}, 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_accum.md
Name: fp_accum

Overview:
- Sequential single-precision (IEEE-754) accumulator sitting directly upstream of, and around, the combinational fp_adder.
- Accepts a stream of `len` 32-bit floats over a valid/ready handshake.
- Feeds each element to its internal fp_adder instance as `b`, with the running accumulator register as `a`, and captures `sum` back into the accumulator.
- Reports the final total with a one-cycle done pulse; used by the multicycle datapath for vector-sum operations.

Parameters:
- CNT_W, default 8: width of the element-count field. Maximum sequence length is 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin new accumulation; sampled only in IDLE.
- len  in  CNT_W  number of elements to sum; sampled with start.
- in_valid  in  1  in_data holds a valid element.
- in_data  in  32  IEEE-754 single-precision element.
- in_ready  out  1  block can accept an element this cycle.
- acc_out  out  32  accumulator value; final sum once done pulses.
- busy  out  1  high in ACCUM and DONE.
- done  out  1  one-cycle pulse: acc_out holds the final sum.
- nan_flag  out  1  sticky invalid-input flag (see Optional Feature).

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE, acc_out=32'h00000000, cnt=0, in_ready=0, busy=0, done=0, nan_flag=0.
- Reset mid-operation: immediately abandons the sequence; all outputs return to reset values; no done pulse.
- One fp_adder instance: a=acc register, b=in_data. The adder is combinational, so an accepted element updates acc on the same clock edge.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - On start: acc<=0, cnt<=len, nan_flag<=0.
  - If len==0, next state is DONE; otherwise next state is ACCUM.
  - acc_out keeps its previous value until start.
- ACCUM:
  - in_ready=1, busy=1.
  - Handshake = in_valid & in_ready. On handshake: acc<=fp_adder.sum, cnt<=cnt-1.
  - If the handshake occurs with cnt==1, next state is DONE.
  - No handshake: hold all registers. Gaps in in_valid are allowed with no limit.
- DONE:
  - done=1 for exactly one cycle, busy=1, in_ready=0.
  - Next state is IDLE unconditionally.
- Latency:
  - done asserts the cycle after the final handshake.
  - For len==0, done asserts the cycle after start.
- start while busy (ACCUM or DONE): ignored; it does not restart or alter cnt/acc.
- start in the same cycle DONE exits: ignored, because the block is not yet in IDLE; it must be re-asserted in IDLE.
- acc_out is driven directly from the acc register, so it is visible mid-sequence and never glitches on in_data changes.
- Rounding, denormal and zero-sign behaviour are exactly those of fp_adder; the block performs no extra normalisation.
- in_data is ignored whenever in_ready=0.

Optional Feature:
- Macro: FP_ACCUM_NAN_DETECT_EN.
- Defined:
  - On each handshake, if in_data[30:23]==8'hFF (NaN or Inf), nan_flag<=1.
  - nan_flag stays set through DONE and IDLE until the next accepted start or reset.
  - Accumulation continues normally.
- Undefined: nan_flag is tied to 0 and no detection logic is synthesised.

Test Plan:
- len=2; elements 3F800000, 3F800000 -> done pulses one cycle after the 2nd handshake; acc_out=40000000; busy low the following cycle.
- len=3; elements 3F800000, 3F000000, 40100000, with in_valid low for 2 cycles between each -> intermediate acc_out 3F800000, then 3FC00000; final 40700000; exactly 3 handshakes.
- len=0; start -> done pulses the next cycle; acc_out=00000000; in_ready never asserts.
- len=2; elements BF800000, 3F800000, with start pulsed again mid-sequence -> restart ignored; final acc_out=00000000; single done pulse.
- len=4; reset asserted asynchronously after 2 handshakes -> outputs immediately at reset values; no done pulse; a new start with len=1, element 3F800000 -> acc_out=3F800000.
- With FP_ACCUM_NAN_DETECT_EN: len=2; elements 7FC00000, 3F800000 -> nan_flag=1 from the 1st handshake through DONE; cleared on the next start. Without the macro, nan_flag stays 0.
